// File: rtl/axi4_stream_pkg.sv
// axi4_stream_pkg: shared types, constants and the counter-pattern step rule
package axi4_stream_pkg;
  typedef enum logic {SEED, CHECK} state_t;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
  localparam logic [31:0] INC_DEF = 32'd1;
  // Zero is never a valid pattern value, so a wrap onto zero skips to inc
  function automatic logic [31:0] next_val(input logic [31:0] x, input logic [31:0] inc);
    logic [31:0] s;
    s = x + inc;
    return (s == 32'd0) ? inc : s;
  endfunction
endpackage

// File: rtl/axi4_stream_data_checker_lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) for backpressure
module lfsr16
  import axi4_stream_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        ACLK,
  input  logic        RST,
  output logic [15:0] state
);
  always_ff @(posedge ACLK or posedge RST)
    if (RST) state <= SEED;
    else state <= {^(state & LFSR_TAPS), state[15:1]};
endmodule

// File: rtl/axi4_stream_data_checker.sv
// axi4_stream_data_checker: AXI4-Stream sink that verifies an incrementing counter pattern
module axi4_stream_data_checker
  import axi4_stream_pkg::*;
#(
  parameter logic [31:0] INC        = INC_DEF,
  parameter logic        READY_MODE = 1'b0,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF
) (
  input  logic        ACLK,
  input  logic        RST,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] TDATA,
  input  logic        TVALID,
  output logic        TREADY,
  output logic [31:0] BEAT_CNT,
  output logic [15:0] ERR_CNT,
  output logic        ERR,
  output logic        LOCKED,
  output logic [31:0] EXP_DATA
);
  state_t      st;
  logic [15:0] lfsr;
  logic        lfsr_unused;
  logic        xfer;
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.ACLK(ACLK), .RST(RST), .state(lfsr));
  assign lfsr_unused = ^lfsr[15:1];
  assign xfer = TVALID & TREADY;
  assign LOCKED = (st == CHECK);
  // Every transfer resyncs EXP_DATA to the received beat, so one slip costs one error
  always_ff @(posedge ACLK or posedge RST)
    if (RST) begin
      st       <= SEED;
      TREADY   <= 1'b0;
      BEAT_CNT <= '0;
      ERR_CNT  <= '0;
      ERR      <= 1'b0;
      EXP_DATA <= '0;
    end else begin
      TREADY <= en & (READY_MODE ? lfsr[0] : 1'b1);
      if (clr) begin
        st       <= SEED;
        BEAT_CNT <= '0;
        ERR_CNT  <= '0;
        ERR      <= 1'b0;
        EXP_DATA <= '0;
      end else if (xfer) begin
        st       <= CHECK;
        BEAT_CNT <= BEAT_CNT + 32'd1;
        EXP_DATA <= next_val(TDATA, INC);
        if (st == CHECK && TDATA != EXP_DATA) begin
          ERR     <= 1'b1;
          ERR_CNT <= ERR_CNT + {15'd0, ~&ERR_CNT};
        end
      end
    end
endmodule

// File: tb/tb_axi4_stream_data_checker.sv
// tb_axi4_stream_data_checker: scoreboard bench for the stream data checker
module tb_axi4_stream_data_checker;
  logic        clk = 1'b0;
  logic        rst, en, clr, tvalid, tvalid1;
  logic [31:0] tdata, tdata1;
  logic        tready, err, locked, tready1, err1, locked1;
  logic [31:0] beat_cnt, exp_data, beat_cnt1, exp1;
  logic [15:0] err_cnt, err_cnt1;
  logic [81:0] st0, st1;
  logic        m_locked, m_errf, m_rdy0, m_rdy1;
  logic [15:0] m_err, m_l;
  logic [31:0] m_exp, m_beat;
  logic [81:0] sb[$];
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  axi4_stream_data_checker #(.READY_MODE(1'b0)) dut0 (
    .ACLK(clk), .RST(rst), .en(en), .clr(clr), .TDATA(tdata), .TVALID(tvalid),
    .TREADY(tready), .BEAT_CNT(beat_cnt), .ERR_CNT(err_cnt), .ERR(err),
    .LOCKED(locked), .EXP_DATA(exp_data));

  axi4_stream_data_checker #(.READY_MODE(1'b1)) dut1 (
    .ACLK(clk), .RST(rst), .en(en), .clr(clr), .TDATA(tdata1), .TVALID(tvalid1),
    .TREADY(tready1), .BEAT_CNT(beat_cnt1), .ERR_CNT(err_cnt1), .ERR(err1),
    .LOCKED(locked1), .EXP_DATA(exp1));

  assign st0 = {locked, err, err_cnt, beat_cnt, exp_data};
  assign st1 = {locked1, err1, err_cnt1, beat_cnt1, exp1};

  // Reference ready model: taps 16,14,13,11 written out as explicit bit XORs
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_l    <= 16'hACE1;
      m_rdy0 <= 1'b0;
      m_rdy1 <= 1'b0;
    end else begin
      m_rdy0 <= en;
      m_rdy1 <= en & m_l[0];
      m_l    <= {m_l[0] ^ m_l[2] ^ m_l[3] ^ m_l[5], m_l[15:1]};
    end

  function automatic logic [31:0] nxt(input logic [31:0] x);
    logic [31:0] s;
    s = x + 32'd1;
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mclear();
    m_locked = 1'b0;
    m_errf   = 1'b0;
    m_err    = '0;
    m_beat   = '0;
    m_exp    = '0;
  endtask

  task automatic send(input logic [31:0] d, input logic c);
    int w;
    logic [81:0] e;
    @(negedge clk);
    tdata = d; tvalid = 1'b1; clr = c; w = 0;
    while (!c && !m_rdy0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", 128'(w < 20), 128'(1));
    if (c) mclear();
    else begin
      if (m_locked && d != m_exp) begin
        m_errf = 1'b1;
        if (m_err != 16'hFFFF) m_err++;
      end
      m_locked = 1'b1;
      m_exp    = nxt(d);
      m_beat++;
    end
    sb.push_back({m_locked, m_errf, m_err, m_beat, m_exp});
    @(posedge clk);
    #1;
    tvalid = 1'b0; clr = 1'b0;
    e = sb.pop_front();
    chk("beat", 128'(st0), 128'(e));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d1, cnt;
    logic x;
    rst = 1'b1; en = 1'b0; clr = 1'b0; tvalid = 1'b0; tdata = '0; tvalid1 = 1'b0; tdata1 = '0;
    mclear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset0", 128'({tready, st0}), 128'(0));
    chk("reset1", 128'({tready1, st1}), 128'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("en_low", 128'(tready), 128'(0));
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    chk("en_rise", 128'(tready), 128'(1));

    for (int i = 1; i <= 1000; i++) send(i, 1'b0);
    chk("clean", 128'(st0), 128'({1'b1, 1'b0, 16'd0, 32'd1000, 32'd1001}));

    send(32'd0, 1'b1);
    send(32'hFFFFFFFE, 1'b0); send(32'hFFFFFFFF, 1'b0); send(32'd1, 1'b0); send(32'd2, 1'b0);
    chk("wrap", 128'(st0), 128'({1'b1, 1'b0, 16'd0, 32'd4, 32'd3}));

    send(32'd0, 1'b1);
    send(32'd10, 1'b0); send(32'd11, 1'b0); send(32'd12, 1'b0); send(32'd14, 1'b0); send(32'd15, 1'b0);
    chk("drop", 128'({err, err_cnt}), 128'({1'b1, 16'd1}));

    send(32'd0, 1'b1);
    send(32'd10, 1'b0); send(32'd11, 1'b0); send(32'd99, 1'b0); send(32'd13, 1'b0);
    chk("corrupt", 128'({err, err_cnt}), 128'({1'b1, 16'd2}));
    send(32'd14, 1'b0);
    chk("sticky", 128'({err, err_cnt, exp_data}), 128'({1'b1, 16'd2, 32'd15}));

    send(32'd50, 1'b1);
    chk("clr_xfer", 128'(st0), 128'(0));
    send(32'd500, 1'b0);
    chk("reseed", 128'(st0), 128'({1'b1, 1'b0, 16'd0, 32'd1, 32'd501}));

    send(32'd0, 1'b1);
    send(32'd0, 1'b0);
    chk("zero_seed", 128'({locked, err_cnt, exp_data}), 128'({1'b1, 16'd0, 32'd1}));
    send(32'd0, 1'b0);
    chk("zero_check", 128'({err, err_cnt}), 128'({1'b1, 16'd1}));

    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    chk("en_fall", 128'(tready), 128'(0));
    @(negedge clk); tvalid = 1'b1; tdata = 32'd777;
    repeat (3) @(posedge clk);
    #1;
    chk("hold", 128'(st0), 128'({m_locked, m_errf, m_err, m_beat, m_exp}));
    @(negedge clk); tvalid = 1'b0; en = 1'b1;

    d1 = 32'd1; cnt = '0; tvalid1 = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      tdata1 = d1;
      chk("bp_ready", 128'(tready1), 128'(m_rdy1));
      x = m_rdy1;
      @(posedge clk);
      if (x) begin
        d1++;
        cnt++;
      end
    end
    @(negedge clk); tvalid1 = 1'b0;
    chk("bp_cnt", 128'(beat_cnt1), 128'(cnt));
    chk("bp_err", 128'({err1, err_cnt1}), 128'(0));
    chk("bp_exp", 128'(exp1), 128'(d1));

    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    @(negedge clk); tvalid = 1'b1; tdata = 32'd6;
    #2 rst = 1'b1;
    #1;
    chk("rst_async0", 128'({tready, st0}), 128'(0));
    chk("rst_async1", 128'({tready1, st1}), 128'(0));
    @(negedge clk); rst = 1'b0; tvalid = 1'b0;
    mclear();
    @(posedge clk); #1;
    chk("after_rst", 128'({tready, st0}), 128'({1'b1, 82'd0}));

    send(32'd5, 1'b0);
    for (int i = 0; i < 65540; i++) send(32'd0, 1'b0);
    chk("saturate", 128'({err, err_cnt, beat_cnt}), 128'({1'b1, 16'hFFFF, 32'd65541}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
